// File: rtl/ibex_lsu_resp_unit.sv
// LSU response unit: tracks outstanding data-bus beats in an in-order descriptor FIFO,
// captures the first beat of misaligned accesses, and produces the aligned and
// sign/zero-extended load result for writeback.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_*_i                 descriptor of a bus beat granted this cycle (pushed on req_issue_i)
//   outstanding_full_o      descriptor FIFO holds MaxOutstanding entries
//   busy_o                  at least one beat outstanding
//   data_rvalid_i/rdata_i/err_i  bus response
//   lsu_resp_valid_o/err_o  access completes this cycle (combinational from rvalid)
//   rf_we_lsu_o/rf_wdata_lsu_o   register-file write of aligned load data
module ibex_lsu_resp_unit #(
  parameter bit          ResetAll       = 1'b0,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_issue_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_type_i,
  input  logic        req_sign_ext_i,
  input  logic [1:0]  req_offset_i,
  input  logic        req_split_i,
  output logic        outstanding_full_o,
  output logic        busy_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o,
  output logic        rf_we_lsu_o,
  output logic [31:0] rf_wdata_lsu_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  localparam logic [1:0] TypeWord = 2'b00;
  localparam logic [1:0] TypeHalf = 2'b01;
  localparam logic [1:0] TypeByte = 2'b10;

  typedef struct packed {
    logic       we;
    logic [1:0] typ;
    logic       sign_ext;
    logic [1:0] offset;
    logic       split;
  } desc_t;

  desc_t            desc_q [MaxOutstanding];
  desc_t            desc_d [MaxOutstanding];
  desc_t            new_desc;
  desc_t            head;
  logic [CntW-1:0]  count_q, count_d, wr_idx;
  logic [31:8]      rdata_q;
  logic             err_q, pend_q;
  logic             full, pop, push;
  logic             resp_valid, resp_err, rf_we;
  logic [31:0]      shifted, raw, ext;

  assign new_desc = '{we: req_we_i, typ: req_type_i, sign_ext: req_sign_ext_i,
                      offset: req_offset_i, split: req_split_i};
  assign head     = desc_q[0];
  assign full     = (count_q == CntW'(MaxOutstanding));
  assign pop      = data_rvalid_i & (count_q != '0);
  // A full FIFO can only accept a beat when the head drains in the same cycle.
  assign push     = req_issue_i & (~full | pop);
  assign wr_idx   = count_q - CntW'(pop);

  // Head sits at index 0; a pop shifts everything down one slot.
  always_comb begin
    desc_d = desc_q;
    if (pop) begin
      for (int i = 0; i < int'(MaxOutstanding) - 1; i++) desc_d[i] = desc_q[i+1];
    end
    if (push) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        if (CntW'(i) == wr_idx) desc_d[i] = new_desc;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
  end

  if (ResetAll) begin : g_desc_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(MaxOutstanding); i++) desc_q[i] <= '0;
      end else begin
        desc_q <= desc_d;
      end
    end
  end else begin : g_desc_norst
    // Stale entries are harmless: count_q decides which slots are live.
    always_ff @(posedge clk_i) begin
      desc_q <= desc_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (pop) begin
        if (head.split) begin
          rdata_q <= data_rdata_i[31:8];
          err_q   <= data_err_i;
          pend_q  <= 1'b1;
        end else begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          pend_q  <= 1'b0;
        end
      end
    end
  end

  // Alignment: pend_q marks that the head is the second beat of a split access.
  assign shifted = data_rdata_i >> {head.offset, 3'b000};

  always_comb begin
    raw = shifted;
    case (head.typ)
      TypeWord: begin
        raw = data_rdata_i;
        if (pend_q) begin
          case (head.offset)
            2'd1:    raw = {data_rdata_i[7:0],  rdata_q[31:8]};
            2'd2:    raw = {data_rdata_i[15:0], rdata_q[31:16]};
            2'd3:    raw = {data_rdata_i[23:0], rdata_q[31:24]};
            default: raw = data_rdata_i;
          endcase
        end
      end
      TypeHalf: begin
        if (pend_q && head.offset == 2'd3) raw = {16'h0, data_rdata_i[7:0], rdata_q[31:24]};
      end
      default: raw = shifted;
    endcase
  end

  always_comb begin
    ext = '0;
    case (head.typ)
      TypeWord: ext = raw;
      TypeHalf: ext = {{16{head.sign_ext & raw[15]}}, raw[15:0]};
      TypeByte: ext = {{24{head.sign_ext & raw[7]}}, raw[7:0]};
      default:  ext = '0;
    endcase
  end

  assign resp_valid = pop & ~head.split;
  assign resp_err   = resp_valid & (data_err_i | err_q);
  assign rf_we      = resp_valid & ~head.we & ~resp_err;

  assign lsu_resp_valid_o   = resp_valid;
  assign lsu_resp_err_o     = resp_err;
  assign rf_we_lsu_o        = rf_we;
  assign rf_wdata_lsu_o     = rf_we ? ext : 32'h0;
  assign outstanding_full_o = full;
  assign busy_o             = (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(req_issue_i && full && !pop))
        else $warning("lsu_resp: issue while full without rvalid, beat dropped");
      assert (!(data_rvalid_i && count_q == '0))
        else $warning("lsu_resp: rvalid with nothing outstanding, ignored");
      assert (!(resp_valid && head.split))
        else $error("lsu_resp: response on first beat of split access");
    end
  end

endmodule

// File: tb/tb_ibex_lsu_resp_unit.sv
module tb_ibex_lsu_resp_unit;

  localparam logic [1:0] W = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] B = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_issue, req_we, req_sign_ext, req_split;
  logic [1:0]  req_type, req_offset;
  logic        full, busy;
  logic        rvalid, rerr;
  logic [31:0] rdata;
  logic        resp_valid, resp_err, rf_we;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  ibex_lsu_resp_unit #(
    .ResetAll       (1'b0),
    .MaxOutstanding (2)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_issue_i        (req_issue),
    .req_we_i           (req_we),
    .req_type_i         (req_type),
    .req_sign_ext_i     (req_sign_ext),
    .req_offset_i       (req_offset),
    .req_split_i        (req_split),
    .outstanding_full_o (full),
    .busy_o             (busy),
    .data_rvalid_i      (rvalid),
    .data_rdata_i       (rdata),
    .data_err_i         (rerr),
    .lsu_resp_valid_o   (resp_valid),
    .lsu_resp_err_o     (resp_err),
    .rf_we_lsu_o        (rf_we),
    .rf_wdata_lsu_o     (rf_wdata)
  );

  typedef struct packed {
    logic        err;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] desc(input logic we, input logic [1:0] t, input logic se,
                                      input logic [1:0] off, input logic sp);
    return {we, t, se, off, sp};
  endfunction

  task automatic expect_resp(input logic err, input logic we, input logic [31:0] wdata);
    sb.push_back('{err: err, we: we, wdata: wdata});
  endtask

  // Drive one cycle of stimulus starting just after a rising edge, then idle the inputs.
  task automatic step(input logic iss, input logic [6:0] d, input logic rv,
                      input logic [31:0] rd, input logic er);
    req_issue = iss;
    {req_we, req_type, req_sign_ext, req_offset, req_split} = d;
    rvalid = rv;
    rdata  = rd;
    rerr   = er;
    @(posedge clk);
    #1;
    req_issue = 1'b0;
    {req_we, req_type, req_sign_ext, req_offset, req_split} = '0;
    rvalid = 1'b0;
    rdata  = '0;
    rerr   = 1'b0;
  endtask

  // Monitor: every presented response must match the oldest expectation.
  exp_t e;
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got valid=1 err=%0b we=%0b data=%h want no response",
                 resp_err, rf_we, rf_wdata);
      end else begin
        e = sb.pop_front();
        check("resp", {resp_err, rf_we, rf_wdata}, {e.err, e.we, e.wdata});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req_issue = 1'b0;
    {req_we, req_type, req_sign_ext, req_offset, req_split} = '0;
    rvalid = 1'b0;
    rdata  = '0;
    rerr   = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy", {33'b0, busy}, 34'd0);
    check("rst_full", {33'b0, full}, 34'd0);
    check("rst_outs", {resp_valid, resp_err, rf_we, rf_wdata[30:0]}, 34'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Aligned word load
    step(1, desc(0, W, 0, 0, 0), 0, 0, 0);
    check("busy_after_issue", {33'b0, busy}, 34'd1);
    step(0, 0, 0, 0, 0);
    expect_resp(0, 1, 32'hDEADBEEF);
    step(0, 0, 1, 32'hDEADBEEF, 0);
    check("busy_after_resp", {33'b0, busy}, 34'd0);

    // Byte loads at offset 2, signed and unsigned
    step(1, desc(0, B, 1, 2, 0), 0, 0, 0);
    expect_resp(0, 1, 32'hFFFFFF80);
    step(0, 0, 1, 32'h00800000, 0);
    step(1, desc(0, B, 0, 2, 0), 0, 0, 0);
    expect_resp(0, 1, 32'h00000080);
    step(0, 0, 1, 32'h00800000, 0);

    // Signed half at offset 2
    step(1, desc(0, H, 1, 2, 0), 0, 0, 0);
    expect_resp(0, 1, 32'hFFFF8001);
    step(0, 0, 1, 32'h80010000, 0);

    // Split word offset 1
    step(1, desc(0, W, 0, 1, 1), 0, 0, 0);
    step(1, desc(0, W, 0, 1, 0), 0, 0, 0);
    step(0, 0, 1, 32'h44332211, 0);
    expect_resp(0, 1, 32'h55443322);
    step(0, 0, 1, 32'h88776655, 0);

    // Split word offset 3, error on first beat only
    step(1, desc(0, W, 0, 3, 1), 0, 0, 0);
    step(1, desc(0, W, 0, 3, 0), 0, 0, 0);
    step(0, 0, 1, 32'h11223344, 1);
    expect_resp(1, 0, 32'h0);
    step(0, 0, 1, 32'h55667788, 0);

    // Following load must not inherit the captured error
    step(1, desc(0, W, 0, 0, 0), 0, 0, 0);
    expect_resp(0, 1, 32'h12345678);
    step(0, 0, 1, 32'h12345678, 0);

    // Split signed half offset 3
    step(1, desc(0, H, 1, 3, 1), 0, 0, 0);
    step(1, desc(0, H, 1, 3, 0), 0, 0, 0);
    step(0, 0, 1, 32'hAB000000, 0);
    expect_resp(0, 1, 32'hFFFFCDAB);
    step(0, 0, 1, 32'h000000CD, 0);

    // Full FIFO with issue and pop in the same cycle
    step(1, desc(0, W, 0, 0, 0), 0, 0, 0);
    step(1, desc(0, W, 0, 0, 0), 0, 0, 0);
    check("full_two", {33'b0, full}, 34'd1);
    expect_resp(0, 1, 32'hAAAA0001);
    step(1, desc(0, W, 0, 0, 0), 1, 32'hAAAA0001, 0);
    check("full_held", {33'b0, full}, 34'd1);
    expect_resp(0, 1, 32'hBBBB0002);
    step(0, 0, 1, 32'hBBBB0002, 0);
    check("full_drop", {33'b0, full}, 34'd0);
    expect_resp(0, 1, 32'hCCCC0003);
    step(0, 0, 1, 32'hCCCC0003, 0);
    check("busy_drained", {33'b0, busy}, 34'd0);

    // Word store
    step(1, desc(1, W, 0, 0, 0), 0, 0, 0);
    expect_resp(0, 0, 32'h0);
    step(0, 0, 1, 32'hFFFFFFFF, 0);

    // Split store, error on second beat
    step(1, desc(1, W, 0, 2, 1), 0, 0, 0);
    step(1, desc(1, W, 0, 2, 0), 0, 0, 0);
    step(0, 0, 1, 32'h0, 0);
    expect_resp(1, 0, 32'h0);
    step(0, 0, 1, 32'h0, 1);

    // Spurious rvalid with nothing outstanding
    step(0, 0, 1, 32'h13572468, 0);
    check("spurious_busy", {33'b0, busy}, 34'd0);

    // Reset with a load outstanding
    step(1, desc(0, W, 0, 0, 0), 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {33'b0, busy}, 34'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 1, 32'h24681357, 0);
    check("postrst_busy", {33'b0, busy}, 34'd0);

    step(0, 0, 0, 0, 0);
    check("sb_drained", 34'(sb.size()), 34'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
